// File: rtl/ads1672_pkg.sv
// Shared types and constants for the ADS1672 capture path.
// Imported by the serial clock generator and the capture sequencer.
package ads1672_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DRDY,
    SHIFT,
    PUSH
  } state_t;

endpackage

// File: rtl/ads1672_sclk_gen.sv
// Free-running serial clock divider for the ADS1672 port.
// Tick strobes mark the clk on whose edge sclk toggles.
module ads1672_sclk_gen
  import ads1672_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap      = (div_cnt == DW'(CLK_DIV - 1));
  assign rise_tick = wrap & ~sclk;
  assign fall_tick = wrap & sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ads1672_capture_ctrl.sv
// ADS1672 capture sequencer: START pulse, DRDY wait, MSB-first
// word shift and valid/ready hand-off, in bursts or continuously.
module ads1672_capture_ctrl
  import ads1672_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W_DEF,
  parameter int CLK_DIV      = 4,
  parameter int DRDY_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [CNT_W-1:0]      cfg_count,
  input  logic                  cfg_stop,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  adc_clkx,
  output logic                  adc_start,
  output logic                  adc_fsx,
  input  logic                  adc_drdy_n,
  input  logic                  adc_drr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(DRDY_TIMEOUT + 1);

  state_t                state;
  state_t                state_nxt;
  logic                  rise_tick;
  logic                  fall_tick;
  logic [CNT_W-1:0]      remaining;
  logic                  cont;
  logic                  stop_pending;
  logic                  rose;
  logic [BW-1:0]         bit_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_in;
  logic                  accept;
  logic                  last;
  logic                  tmo_hit;
  logic                  word_end;
  logic                  ending;

  ads1672_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (adc_clkx),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  assign adc_fsx  = adc_start;
  assign shreg_in = {shreg[DATA_WIDTH-2:0], adc_drr};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tmo_hit   = 1'b0;
    word_end  = 1'b0;
    last      = stop_pending | cfg_stop |
                (~cont & (remaining == CNT_W'(1)));
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (fall_tick && rose)
          state_nxt = WAIT_DRDY;
      end
      WAIT_DRDY: begin
        if (fall_tick) begin
          if (!adc_drdy_n) begin
            state_nxt = SHIFT;
          end else if (tmo_cnt == TW'(DRDY_TIMEOUT - 1)) begin
            tmo_hit   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      SHIFT: begin
        if (fall_tick && bit_cnt == BW'(DATA_WIDTH - 1)) begin
          word_end  = 1'b1;
          state_nxt = PUSH;
        end
      end
      PUSH: begin
        if (m_ready)
          state_nxt = last ? IDLE : START;
      end
      default: state_nxt = IDLE;
    endcase
    ending = (state != IDLE) && (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      adc_start    <= 1'b0;
      rose         <= 1'b0;
      stop_pending <= 1'b0;
      cont         <= 1'b0;
      remaining    <= '0;
      tmo_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
    end else begin
      done <= ending;
      if (accept) begin
        busy        <= 1'b1;
        timeout_err <= 1'b0;
        remaining   <= cfg_count;
        cont        <= (cfg_count == '0);
      end else if (ending) begin
        busy <= 1'b0;
      end
      if (tmo_hit)
        timeout_err <= 1'b1;
      if (accept)
        stop_pending <= cfg_stop;
      else if (ending)
        stop_pending <= 1'b0;
      else if (cfg_stop && state != IDLE)
        stop_pending <= 1'b1;
      // START spans fall -> rise -> fall so exactly one rising edge sees it
      if (state == START) begin
        if (fall_tick && rose) begin
          adc_start <= 1'b0;
          rose      <= 1'b0;
          tmo_cnt   <= '0;
        end else if (fall_tick) begin
          adc_start <= 1'b1;
        end else if (rise_tick && adc_start) begin
          rose <= 1'b1;
        end
      end
      if (state == WAIT_DRDY && fall_tick) begin
        if (!adc_drdy_n) begin
          shreg   <= shreg_in;
          bit_cnt <= BW'(1);
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
      if (state == SHIFT && fall_tick) begin
        shreg   <= shreg_in;
        bit_cnt <= bit_cnt + 1'b1;
        if (word_end) begin
          m_data  <= shreg_in;
          m_valid <= 1'b1;
        end
      end
      if (state == PUSH && m_ready) begin
        m_valid <= 1'b0;
        if (!cont)
          remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ads1672_capture_ctrl.sv
// Bench for ads1672_capture_ctrl: three instances at CLK_DIV 4, 2, 7,
// each driven by a behavioural ADC that launches bits on rising sclk.
module tb_ads1672_capture_ctrl;

  localparam int ND = 3;
  localparam int W  = 24;
  localparam logic [W-1:0] FIXED = 24'hCACF0C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic         cfg_start_a [ND];
  logic [15:0]  cfg_count_a [ND];
  logic         cfg_stop_a  [ND];
  logic         m_ready_a   [ND];
  logic         fixed_a     [ND];
  logic         drdy_en_a   [ND];
  logic         busy_a      [ND];
  logic         done_a      [ND];
  logic         terr_a      [ND];
  logic         clkx_a      [ND];
  logic         start_a     [ND];
  logic         fsx_a       [ND];
  logic         mvalid_a    [ND];
  logic [W-1:0] mdata_a     [ND];
  int           conv_a      [ND];
  int           bitpos_a    [ND];
  int           nst_a       [ND];
  logic [W-1:0] rnd_words   [256];

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 2 : 7);
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int CD = (g == 0) ? 4 : ((g == 1) ? 2 : 7);
    logic         drdy_n;
    logic         drr;
    logic [W-1:0] sh;
    logic [W-1:0] wsel;
    int           conv = 0;
    int           bitpos = 0;
    int           dly = 0;
    int           nst = 0;

    ads1672_capture_ctrl #(
      .DATA_WIDTH  (W),
      .CLK_DIV     (CD),
      .DRDY_TIMEOUT(64)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_start  (cfg_start_a[g]),
      .cfg_count  (cfg_count_a[g]),
      .cfg_stop   (cfg_stop_a[g]),
      .busy       (busy_a[g]),
      .done       (done_a[g]),
      .timeout_err(terr_a[g]),
      .adc_clkx   (clkx_a[g]),
      .adc_start  (start_a[g]),
      .adc_fsx    (fsx_a[g]),
      .adc_drdy_n (drdy_n),
      .adc_drr    (drr),
      .m_data     (mdata_a[g]),
      .m_valid    (mvalid_a[g]),
      .m_ready    (m_ready_a[g])
    );

    assign wsel = fixed_a[g] ? FIXED : rnd_words[conv[7:0]];

    // ADC: START seen on a rising edge, DRDY+MSB two rising edges later
    always @(posedge clkx_a[g] or negedge rst_n) begin
      if (!rst_n) begin
        drdy_n <= 1'b1;
        drr    <= 1'b0;
        dly    <= 0;
        bitpos <= 0;
      end else begin
        drdy_n <= 1'b1;
        if (start_a[g]) begin
          dly    <= 2;
          bitpos <= 0;
        end else if (dly > 0) begin
          dly <= dly - 1;
          if (dly == 1 && drdy_en_a[g]) begin
            sh     <= wsel;
            drr    <= wsel[W-1];
            drdy_n <= 1'b0;
            bitpos <= W - 1;
            conv   <= conv + 1;
          end
        end else if (bitpos > 0) begin
          drr    <= sh[bitpos-1];
          bitpos <= bitpos - 1;
        end
      end
    end

    always @(posedge start_a[g]) nst <= nst + 1;

    assign conv_a[g]   = conv;
    assign bitpos_a[g] = bitpos;
    assign nst_a[g]    = nst;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W+6:0] outs(input int d);
    return {busy_a[d], done_a[d], terr_a[d], clkx_a[d],
            start_a[d], fsx_a[d], mvalid_a[d], mdata_a[d]};
  endfunction

  task automatic pulse_start(input int d, input int n, input bit stp);
    cfg_count_a[d] = 16'(n);
    cfg_start_a[d] = 1'b1;
    cfg_stop_a[d]  = stp;
    @(negedge clk);
    cfg_start_a[d] = 1'b0;
    cfg_stop_a[d]  = 1'b0;
  endtask

  // stop_w: -1 none, -2 together with cfg_start, k>=0 mid-shift of word k
  task automatic run_burst(input int d, input int n, input int stop_w,
                           input int stall_w, input bit fixed,
                           input bit rnd, input int exp_words);
    logic [W-1:0] q[$];
    int  base, st0, words, dones, extra, stall_left;
    int  stall_bad, fsx_bad, sp_bad, rises, last_rise;
    bit  fin, stop_sent, prev_st;
    words = 0; dones = 0; extra = 0; stall_left = 100;
    stall_bad = 0; fsx_bad = 0; sp_bad = 0; rises = 0;
    last_rise = 0; fin = 0; stop_sent = 0; prev_st = 0;
    fixed_a[d] = fixed;
    m_ready_a[d] = 1'b1;
    @(negedge clk);
    base = conv_a[d];
    st0  = nst_a[d];
    for (int k = 0; k < exp_words; k++)
      q.push_back(fixed ? FIXED : rnd_words[(base + k) % 256]);
    pulse_start(d, n, stop_w == -2);
    chk("busy_set", 64'(busy_a[d]), 64'd1);
    chk("terr_clear", 64'(terr_a[d]), 64'd0);
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (mvalid_a[d] && words == stall_w && stall_left > 0) begin
        m_ready_a[d] = 1'b0;
        stall_left--;
        if (start_a[d]) stall_bad++;
      end else begin
        m_ready_a[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (mvalid_a[d] && m_ready_a[d]) begin
        if (q.size() > 0)
          chk($sformatf("word%0d", words), 64'(mdata_a[d]),
              64'(q.pop_front()));
        words++;
      end
      cfg_stop_a[d] = 1'b0;
      if (stop_w >= 0 && !stop_sent &&
          conv_a[d] == base + stop_w + 1 && bitpos_a[d] == 10) begin
        cfg_stop_a[d] = 1'b1;
        stop_sent = 1'b1;
      end
      if (fsx_a[d] !== start_a[d]) fsx_bad++;
      if (start_a[d] && !prev_st) begin
        if (rises > 0 && cyc - last_rise != (W + 3) * 2 * div_of(d))
          sp_bad++;
        rises++;
        last_rise = cyc;
      end
      prev_st = start_a[d];
      if (done_a[d]) begin
        dones++;
        chk("busy_at_done", 64'(busy_a[d]), 64'd0);
        fin = 1'b1;
      end
      @(negedge clk);
    end
    cfg_stop_a[d] = 1'b0;
    m_ready_a[d]  = 1'b1;
    chk("burst_finished", 64'(fin), 64'd1);
    repeat (40) begin
      if (done_a[d] || mvalid_a[d]) extra++;
      @(negedge clk);
    end
    chk("words", 64'(words), 64'(exp_words));
    chk("done_pulses", 64'(dones), 64'd1);
    chk("no_extra", 64'(extra), 64'd0);
    chk("start_count", 64'(nst_a[d] - st0), 64'(exp_words));
    chk("fsx_eq_start", 64'(fsx_bad), 64'd0);
    if (!rnd && stall_w < 0)
      chk("start_spacing", 64'(sp_bad), 64'd0);
    if (stall_w >= 0)
      chk("stall_start_low", 64'(stall_bad), 64'd0);
  endtask

  typedef struct {
    int d;
    int n;
    int stop_w;
    int stall_w;
    bit fixed;
    bit rnd;
    int exp_words;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tf, td, mv, c0, c1, seen;
    bit pv, fin;
    for (int i = 0; i < ND; i++) begin
      cfg_start_a[i] = 1'b0;
      cfg_count_a[i] = '0;
      cfg_stop_a[i]  = 1'b0;
      m_ready_a[i]   = 1'b1;
      fixed_a[i]     = 1'b1;
      drdy_en_a[i]   = 1'b1;
    end
    for (int k = 0; k < 256; k++) rnd_words[k] = W'($urandom);

    tbl[0] = '{0, 1, -1, -1, 1'b1, 1'b0, 1};
    tbl[1] = '{0, 3, -1,  1, 1'b1, 1'b0, 3};
    tbl[2] = '{0, 0,  4, -1, 1'b1, 1'b0, 5};
    tbl[3] = '{0, 0, -2, -1, 1'b1, 1'b0, 1};
    tbl[4] = '{1, 1, -1, -1, 1'b1, 1'b0, 1};
    tbl[5] = '{2, 1, -1, -1, 1'b1, 1'b0, 1};
    tbl[6] = '{0, 2, -1, -1, 1'b0, 1'b0, 2};

    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++)
      chk($sformatf("reset_outs%0d", d), 64'(outs(d)), 64'd0);
    rst_n = 1'b1;

    for (int d = 0; d < ND; d++) begin
      c0 = 0; c1 = 0; seen = 0;
      pv = clkx_a[d];
      for (int c = 0; c < 100 && seen < 2; c++) begin
        @(negedge clk);
        if (clkx_a[d] && !pv) begin
          if (seen == 0) c0 = c;
          else           c1 = c;
          seen++;
        end
        pv = clkx_a[d];
      end
      chk($sformatf("clkx_period%0d", d), 64'(c1 - c0),
          64'(2 * div_of(d)));
    end

    for (int i = 0; i < 7; i++)
      run_burst(tbl[i].d, tbl[i].n, tbl[i].stop_w, tbl[i].stall_w,
                tbl[i].fixed, tbl[i].rnd, tbl[i].exp_words);

    // DRDY never arrives
    drdy_en_a[0] = 1'b0;
    pulse_start(0, 1, 1'b0);
    tf = -1; td = -1; mv = 0; pv = 1'b0; fin = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (pv && !start_a[0]) tf = c;
      pv = start_a[0];
      if (mvalid_a[0]) mv++;
      if (done_a[0]) begin
        td  = c;
        fin = 1'b1;
      end
      @(negedge clk);
    end
    chk("tmo_cycles", 64'(td - tf), 64'(64 * 2 * 4));
    chk("tmo_err", 64'(terr_a[0]), 64'd1);
    chk("tmo_no_mvalid", 64'(mv), 64'd0);
    chk("tmo_busy", 64'(busy_a[0]), 64'd0);
    drdy_en_a[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("tmo_err_sticky", 64'(terr_a[0]), 64'd1);
    run_burst(0, 1, -1, -1, 1'b1, 1'b0, 1);

    // reset in the middle of a word
    fixed_a[0] = 1'b1;
    pulse_start(0, 1, 1'b0);
    fin = 1'b0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (bitpos_a[0] == 12) fin = 1'b1;
      else @(negedge clk);
    end
    chk("reached_shift", 64'(fin), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 64'(outs(0)), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", 64'(outs(0)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(0, 1, -1, -1, 1'b1, 1'b0, 1);

    // randomized bursts, data and backpressure
    for (int r = 0; r < 8; r++) begin
      int d, n, sw;
      d = int'($urandom_range(0, 2));
      if (r % 2 == 1) begin
        sw = int'($urandom_range(0, 2));
        run_burst(d, 0, sw, -1, 1'b0, 1'b1, sw + 1);
      end else begin
        n = int'($urandom_range(1, 4));
        run_burst(d, n, -1, -1, 1'b0, 1'b1, n);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ads1672_capture_ctrl.md
# ads1672_capture_ctrl

FPGA-side sequencer for the ADS1672 serial data port. Generates the serial clock, pulses START once per conversion, waits for DRDY, shifts in one DATA_WIDTH-bit word MSB-first and hands it downstream on a valid/ready stream. Runs bursts of N samples, or continuous capture until stopped. Sits between the register/command logic and the sample FIFO.

## Interface
- DATA_WIDTH, 24: bits per conversion word.
- CLK_DIV, 4: clk cycles per serial-clock half period; legal range ≥ 2.
- DRDY_TIMEOUT, 64: serial-clock periods to wait for DRDY before flagging an error.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  one-clk pulse; latches cfg_count and begins a burst; ignored while busy.
- cfg_count  in  16  samples per burst; 0 = continuous until cfg_stop.
- cfg_stop  in  1  one-clk pulse; ends the burst at the next word boundary.
- busy  out  1  high from the clk after an accepted cfg_start until the burst ends.
- done  out  1  one-clk pulse when a burst ends, normally or by stop.
- timeout_err  out  1  sticky; set on DRDY timeout; cleared by an accepted cfg_start.
- adc_clkx  out  1  serial clock to the ADC.
- adc_start  out  1  START pin.
- adc_fsx  out  1  frame sync to the ADC; equals adc_start.
- adc_drdy_n  in  1  data-ready, active-low; low for the MSB bit period.
- adc_drr  in  1  serial data; changes on rising adc_clkx.
- m_data  out  DATA_WIDTH  captured word, MSB = first received bit.
- m_valid  out  1  word available.
- m_ready  in  1  downstream accept.

## Operation
- Serial clock runs continuously out of reset. rise_tick and fall_tick are one-clk strobes on the clk where adc_clkx toggles high or low, respectively.
- All ADC inputs are sampled only on fall_tick, half a serial period after the device launches them.
- States: IDLE, START, WAIT_DRDY, SHIFT, PUSH.
- IDLE: on cfg_start, latch the count, clear timeout_err, set busy, and go to START.
- START: adc_start/adc_fsx rise on the next fall_tick and fall on the following fall_tick, covering exactly one rising edge. Then go to WAIT_DRDY with the timeout counter cleared.
- WAIT_DRDY: on each fall_tick, if adc_drdy_n = 0, shift in adc_drr as the MSB, set bit_cnt = 1, and go to SHIFT. Otherwise increment the timeout counter. When it reaches DRDY_TIMEOUT, set timeout_err, pulse done, and go to IDLE.
- SHIFT: on each fall_tick, shift adc_drr in at the LSB and increment bit_cnt. When bit_cnt reaches DATA_WIDTH, load m_data, set m_valid, and go to PUSH.
- PUSH: hold m_data/m_valid until m_ready. On handshake:
  - decrement the remaining count (continuous mode does not decrement);
  - if the remaining count hits 0 or stop is pending, pulse done and go to IDLE;
  - otherwise go to START.
- Backpressure stalls the burst. No new START is issued while a word is unaccepted, so no data is lost.
- cfg_stop sets stop_pending in any non-IDLE state. The word in progress completes and is delivered.
  - cfg_stop in IDLE is ignored.
  - cfg_stop on the same clk as cfg_start: the start is accepted, and one word is captured before ending.
- The remaining count is 16-bit. Continuous mode never wraps it.

## Timing
- Reset values: adc_clkx 0, adc_start 0, adc_fsx 0, busy 0, done 0, timeout_err 0, m_valid 0, m_data 0. The divider counter, bit_cnt and stop_pending are also cleared; state = IDLE.
- Reset asserted mid-burst aborts immediately. No done pulse.
- Serial period = 2·CLK_DIV clk.
- Nominal per-word latency, START entry to m_valid: ≤ (DATA_WIDTH + 3) serial periods.
- m_valid rises on the clk after the fall_tick that captures the LSB.
- With m_ready held high, consecutive words are spaced DATA_WIDTH + 3 serial periods.
- done and the busy deassertion occur on the same clk edge, one clk after the final handshake.

## Structure
- Package ads1672_pkg holds:
  - the state enum (IDLE, START, WAIT_DRDY, SHIFT, PUSH);
  - the default DATA_WIDTH constant;
  - the count width constant (16).
- Sub-module ads1672_sclk_gen (params CLK_DIV; outputs sclk, rise_tick, fall_tick) holds the divider. The FSM lives in the top module.

## Test plan
- Single sample: cfg_count = 1, ADC bus model returns 0xCACF0C, m_ready = 1 -> one m_valid with m_data = 0xCACF0C, then done pulses once and busy = 0.
- Burst with backpressure: cfg_count = 3, m_ready low for 100 clk on word 2 -> exactly 3 words of 0xCACF0C; adc_start stays low during the stall; 3 START pulses total.
- Continuous + stop: cfg_count = 0, cfg_stop pulsed mid-SHIFT of word 5 -> word 5 delivered intact, then done; no 6th START.
- Timeout: model never asserts DRDY -> timeout_err = 1 after 64 serial periods in WAIT_DRDY, done pulses, no m_valid; the next cfg_start clears timeout_err.
- Reset mid-SHIFT: rst_n low for 3 clk -> all outputs at reset values immediately; a subsequent burst returns a correct 0xCACF0C.
- CLK_DIV = 2 and CLK_DIV = 7 runs -> adc_clkx period of 4 and 14 clk respectively; captured data identical.
